// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro: CHANGE_COIN1_EN enables the 1-unit coin.
package change_pkg;

  // Money width, matching the vending machine's outputs.
  localparam int MONEY_W = 7;

  // Coin denominations, as presented on the 6-bit coin_value bus.
  localparam logic [5:0] COIN_50 = 6'd50;
  localparam logic [5:0] COIN_10 = 6'd10;
  localparam logic [5:0] COIN_5  = 6'd5;
  localparam logic [5:0] COIN_1  = 6'd1;

  // Smallest coin the hopper can pay in this build; any remainder below it
  // cannot be dispensed and ends the payout.
`ifdef CHANGE_COIN1_EN
  localparam logic [5:0] COIN_MIN = COIN_1;
`else
  localparam logic [5:0] COIN_MIN = COIN_5;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DISP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Coin handshake between the dispenser (master) and the coin-hopper driver (slave).
// Latency: n/a (wires only).
// Backpressure: coin_value is held while coin_valid=1 until coin_ready accepts it.
// Signals: coin_valid / coin_value (master -> slave), coin_ready (slave -> master).
interface change_dispenser_if;
  logic       coin_valid;
  logic [5:0] coin_value;
  logic       coin_ready;

  modport master (
    output coin_valid,
    output coin_value,
    input  coin_ready
  );

  modport slave (
    input  coin_valid,
    input  coin_value,
    output coin_ready
  );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational pick of the largest denomination not exceeding the remaining amount.
// Latency: 0 cycles.
// Backpressure: none (pure function of remain_i).
// Ports: remain_i (amount still owed), coin_o (chosen coin, 0 if none fits).
// Optional feature macro: CHANGE_COIN1_EN adds the 1-unit branch.
module coin_select
  import change_pkg::*;
#(
  parameter int W = MONEY_W
) (
  input  logic [W-1:0] remain_i,
  output logic [5:0]   coin_o
);

  always_comb begin
    coin_o = '0;
    if (remain_i >= W'(COIN_50)) begin
      coin_o = COIN_50;
    end else if (remain_i >= W'(COIN_10)) begin
      coin_o = COIN_10;
    end else if (remain_i >= W'(COIN_5)) begin
      coin_o = COIN_5;
`ifdef CHANGE_COIN1_EN
    end else if (remain_i >= W'(COIN_1)) begin
      coin_o = COIN_1;
`endif
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Captures total/cost, computes change and pays it out one coin per handshake, largest first.
// Latency: start edge -> CALC (1 cycle) -> one coin per accepted handshake -> one-cycle done pulse.
// Backpressure: coin stays presented (value frozen) while coin_ready=0; start ignored while busy.
// Ports: clk, reset (async active-low), start, totalMoney, costOfTicket,
//        coin (change_dispenser_if.master), busy, done, short_pay, change_total, residue.
// Optional feature macro: CHANGE_COIN1_EN (adds the 1-unit coin; residue then always 0).
module change_dispenser
  import change_pkg::*;
#(
  parameter int W = MONEY_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [W-1:0]        totalMoney,
  input  logic [W-1:0]        costOfTicket,
  change_dispenser_if.master  coin,
  output logic                busy,
  output logic                done,
  output logic                short_pay,
  output logic [W-1:0]        change_total,
  output logic [2:0]          residue
);

  state_t         state_q, state_d;
  logic [W-1:0]   total_q, total_d;
  logic [W-1:0]   cost_q, cost_d;
  logic [W-1:0]   remain_q, remain_d;
  logic [W-1:0]   change_q, change_d;
  logic           short_q, short_d;
  logic [2:0]     residue_q, residue_d;

  logic [5:0]     sel_coin;
  logic           enough;
  logic [W-1:0]   calc_amt;
  logic [W-1:0]   remain_after;

  coin_select #(.W(W)) u_coin_select (
    .remain_i (remain_q),
    .coin_o   (sel_coin)
  );

  // Subtraction is only used when the compare says it cannot wrap.
  assign enough       = (total_q >= cost_q);
  assign calc_amt     = enough ? (total_q - cost_q) : '0;
  assign remain_after = remain_q - W'(sel_coin);

  always_comb begin
    state_d         = state_q;
    total_d         = total_q;
    cost_d          = cost_q;
    remain_d        = remain_q;
    change_d        = change_q;
    short_d         = short_q;
    residue_d       = residue_q;
    coin.coin_valid = 1'b0;
    coin.coin_value = '0;
    busy            = (state_q != ST_IDLE);
    done            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          total_d   = totalMoney;
          cost_d    = costOfTicket;
          short_d   = 1'b0;
          residue_d = '0;
          state_d   = ST_CALC;
        end
      end

      ST_CALC: begin
        change_d = calc_amt;
        remain_d = calc_amt;
        short_d  = ~enough;
        if (calc_amt >= W'(COIN_MIN)) begin
          state_d = ST_DISP;
        end else begin
          // Change too small for any coin is reported as unpaid residue.
          residue_d = calc_amt[2:0];
          state_d   = ST_DONE;
        end
      end

      ST_DISP: begin
        // remain_q only moves on acceptance, so the presented coin is stable
        // for as long as the hopper stalls.
        coin.coin_valid = 1'b1;
        coin.coin_value = sel_coin;
        if (coin.coin_ready) begin
          remain_d = remain_after;
          if (remain_after < W'(COIN_MIN)) begin
            residue_d = remain_after[2:0];
            state_d   = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      cost_q    <= '0;
      remain_q  <= '0;
      change_q  <= '0;
      short_q   <= 1'b0;
      residue_q <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      cost_q    <= cost_d;
      remain_q  <= remain_d;
      change_q  <= change_d;
      short_q   <= short_d;
      residue_q <= residue_d;
    end
  end

  assign short_pay    = short_q;
  assign change_total = change_q;
  assign residue      = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed, table-driven bench for change_dispenser with hand-computed expectations.
// Latency: checks done arrives (coins + 2) cycles after the start edge.
// Backpressure: exercises coin_ready stalls, start during payout and reset mid-payout.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] totalMoney;
  logic [6:0] costOfTicket;
  logic       busy;
  logic       done;
  logic       short_pay;
  logic [6:0] change_total;
  logic [2:0] residue;

  change_dispenser_if cif ();

  change_dispenser #(.W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .totalMoney   (totalMoney),
    .costOfTicket (costOfTicket),
    .coin         (cif),
    .busy         (busy),
    .done         (done),
    .short_pay    (short_pay),
    .change_total (change_total),
    .residue      (residue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]      total;
    logic [6:0]      cost;
    int              exp_change;
    int              exp_short;
    int              exp_residue;
    int              n_coins;
    logic [7:0][5:0] coins;
    int              inj_cyc;   // cycle at which a stray start is pulsed, -1 = none
  } vec_t;

  function automatic logic [7:0][5:0] seq(input int a, input int b, input int c,
                                          input int d, input int e, input int f,
                                          input int g);
    logic [7:0][5:0] s;
    s    = '0;
    s[0] = a[5:0]; s[1] = b[5:0]; s[2] = c[5:0]; s[3] = d[5:0];
    s[4] = e[5:0]; s[5] = f[5:0]; s[6] = g[5:0];
    return s;
  endfunction

  function automatic vec_t mk(input int t, input int c, input int ch, input int sh,
                              input int res, input int n, input logic [7:0][5:0] cs,
                              input int inj);
    vec_t v;
    v.total       = t[6:0];
    v.cost        = c[6:0];
    v.exp_change  = ch;
    v.exp_short   = sh;
    v.exp_residue = res;
    v.n_coins     = n;
    v.coins       = cs;
    v.inj_cyc     = inj;
    return v;
  endfunction

  int got_coins[16];
  int got_n;
  int got_done;
  int busy_calc;

  // Pulse start with the given inputs, then observe one cycle per negedge until done.
  task automatic run_txn(input logic [6:0] t, input logic [6:0] c, input int inj);
    @(negedge clk);
    totalMoney   = t;
    costOfTicket = c;
    start        = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    got_n     = 0;
    got_done  = -1;
    busy_calc = int'(busy);
    for (int cyc = 1; cyc < 40 && got_done < 0; cyc++) begin
      if (cif.coin_valid) begin
        if (got_n < 16) got_coins[got_n] = int'(cif.coin_value);
        got_n++;
      end
      if (done) got_done = cyc;
      if (cyc == inj) begin
        start        = 1'b1;
        totalMoney   = 7'd20;
        costOfTicket = 7'd35;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (got_done < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles expected done");
    end
  endtask

  vec_t vecs[7];

  initial begin
    reset            = 1'b0;
    start            = 1'b0;
    totalMoney       = '0;
    costOfTicket     = '0;
    cif.coin_ready   = 1'b1;

`ifdef CHANGE_COIN1_EN
    vecs[0] = mk(60, 45, 15, 0, 0, 2, seq(10, 5, 0, 0, 0, 0, 0), -1);
    vecs[1] = mk(65, 7, 58, 0, 0, 5, seq(50, 5, 1, 1, 1, 0, 0), -1);
    vecs[2] = mk(20, 35, 0, 1, 0, 0, seq(0, 0, 0, 0, 0, 0, 0), -1);
    vecs[3] = mk(127, 0, 127, 0, 0, 7, seq(50, 50, 10, 10, 5, 1, 1), -1);
    vecs[4] = mk(40, 40, 0, 0, 0, 0, seq(0, 0, 0, 0, 0, 0, 0), -1);
    vecs[5] = mk(12, 9, 3, 0, 0, 3, seq(1, 1, 1, 0, 0, 0, 0), -1);
    vecs[6] = mk(127, 0, 127, 0, 0, 7, seq(50, 50, 10, 10, 5, 1, 1), 3);
`else
    vecs[0] = mk(60, 45, 15, 0, 0, 2, seq(10, 5, 0, 0, 0, 0, 0), -1);
    vecs[1] = mk(65, 7, 58, 0, 3, 2, seq(50, 5, 0, 0, 0, 0, 0), -1);
    vecs[2] = mk(20, 35, 0, 1, 0, 0, seq(0, 0, 0, 0, 0, 0, 0), -1);
    vecs[3] = mk(127, 0, 127, 0, 2, 5, seq(50, 50, 10, 10, 5, 0, 0), -1);
    vecs[4] = mk(40, 40, 0, 0, 0, 0, seq(0, 0, 0, 0, 0, 0, 0), -1);
    vecs[5] = mk(12, 9, 3, 0, 3, 0, seq(0, 0, 0, 0, 0, 0, 0), -1);
    vecs[6] = mk(127, 0, 127, 0, 2, 5, seq(50, 50, 10, 10, 5, 0, 0), 3);
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_coin_valid", int'(cif.coin_valid), 0);
    chk("rst_coin_value", int'(cif.coin_value), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short_pay", int'(short_pay), 0);
    chk("rst_change_total", int'(change_total), 0);
    chk("rst_residue", int'(residue), 0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven transactions with coin_ready held high.
    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].total, vecs[v].cost, vecs[v].inj_cyc);
      chk($sformatf("v%0d_busy_calc", v), busy_calc, 1);
      chk($sformatf("v%0d_change_total", v), int'(change_total), vecs[v].exp_change);
      chk($sformatf("v%0d_short_pay", v), int'(short_pay), vecs[v].exp_short);
      chk($sformatf("v%0d_residue", v), int'(residue), vecs[v].exp_residue);
      chk($sformatf("v%0d_n_coins", v), got_n, vecs[v].n_coins);
      for (int i = 0; i < vecs[v].n_coins && i < got_n && i < 8; i++) begin
        chk($sformatf("v%0d_coin%0d", v, i), got_coins[i], int'(vecs[v].coins[i]));
      end
      chk($sformatf("v%0d_done_cycle", v), got_done, vecs[v].n_coins + 2);
      chk($sformatf("v%0d_busy_after", v), int'(busy), 0);
    end

    // Stall: coin_ready low for 3 cycles while a 10 is presented.
    @(negedge clk);
    totalMoney     = 7'd30;
    costOfTicket   = 7'd15;
    cif.coin_ready = 1'b0;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), int'(cif.coin_valid), 1);
      chk($sformatf("stall%0d_value", k), int'(cif.coin_value), 10);
      @(negedge clk);
    end
    chk("stall_value_before_accept", int'(cif.coin_value), 10);
    cif.coin_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_valid", int'(cif.coin_valid), 1);
    chk("stall_next_value", int'(cif.coin_value), 5);
    @(negedge clk);
    chk("stall_done", int'(done), 1);
    chk("stall_valid_in_done", int'(cif.coin_valid), 0);
    chk("stall_change_total", int'(change_total), 15);
    @(negedge clk);

    // Reset in the middle of a payout.
    totalMoney   = 7'd127;
    costOfTicket = 7'd0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", int'(cif.coin_valid), 1);
    reset = 1'b0;
    #1;
    chk("midrst_coin_valid", int'(cif.coin_valid), 0);
    chk("midrst_coin_value", int'(cif.coin_value), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_change_total", int'(change_total), 0);
    chk("midrst_short_pay", int'(short_pay), 0);
    chk("midrst_residue", int'(residue), 0);
    @(negedge clk);
    reset = 1'b1;
    run_txn(7'd10, 7'd5, -1);
    chk("post_rst_n_coins", got_n, 1);
    if (got_n >= 1) chk("post_rst_coin0", got_coins[0], 5);
    chk("post_rst_change_total", int'(change_total), 5);
    chk("post_rst_done_cycle", got_done, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
